// File: rtl/ifid_pkg.sv
// rtl/ifid_pkg.sv - shared constants and packed entry layout for the IF/ID queue
// Entry grows from 49 to 51 bits when IFID_PREDECODE_EN is defined.
package ifid_pkg;

   localparam logic [15:0] IFID_NOP_INSTR = 16'h0800;
   localparam logic [4:0]  IFID_HALT_OPC  = 5'b00000;
   localparam logic [2:0]  BRANCH_PFX     = 3'b011;
   localparam logic [2:0]  JUMP_PFX       = 3'b001;

   localparam int INSTR_W     = 16;
   localparam int PC_W        = 16;
   localparam int INSTR_LSB   = 0;
   localparam int PC_CURR_LSB = 16;
   localparam int PC_NEXT_LSB = 32;
   localparam int PRED_BIT    = 48;
   localparam int BRANCH_BIT  = 49;
   localparam int JUMP_BIT    = 50;

`ifdef IFID_PREDECODE_EN
   localparam int ENTRY_W = 51;
`else
   localparam int ENTRY_W = 49;
`endif

   function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] opc);
      return instr[15:11] == opc;
   endfunction

endpackage

// File: rtl/ifid_slot.sv
// rtl/ifid_slot.sv - single queue entry register with write-enable
// Cleared asynchronously by the active-low reset.
module ifid_slot
   import ifid_pkg::*;
#(
   parameter int W = ENTRY_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ifid_queue.sv
// rtl/ifid_queue.sv - IF/ID instruction buffer with flush, halt capture and NOP bubbles
// Optional predecode outputs enabled by macro IFID_PREDECODE_EN.
module ifid_queue
   import ifid_pkg::*;
#(
   parameter int          DEPTH     = 2,
   parameter logic [15:0] NOP_INSTR = IFID_NOP_INSTR,
   parameter logic [4:0]  HALT_OPC  = IFID_HALT_OPC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [15:0]              in_instr,
   input  logic [15:0]              in_pc_curr,
   input  logic [15:0]              in_pc_next,
   input  logic                     in_pred_taken,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [15:0]              out_instr,
   output logic [15:0]              out_pc_curr,
   output logic [15:0]              out_pc_next,
   output logic                     out_pred_taken,
   output logic                     out_is_branch,
   output logic                     out_is_jump,
   output logic                     halt_seen,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;
   logic [PW-1:0]      wr_idx;
   logic               push;
   logic               pop;
   logic               in_halt;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic [ENTRY_W-1:0] slot_q [DEPTH];

   // in_ready depends only on registered state so fetch never sees a path from decode stall.
   assign in_ready = (count < CW'(DEPTH)) && !halt_seen;
   assign push     = in_valid && (flush || in_ready);
   assign pop      = out_valid && out_ready && !flush;
   assign err      = in_valid && !in_ready && !flush;
   assign in_halt  = is_halt(in_instr, HALT_OPC);
   assign wr_idx   = flush ? '0 : tail;

   always_comb begin
      wr_entry = '0;
      wr_entry[INSTR_LSB +: INSTR_W] = in_instr;
      wr_entry[PC_CURR_LSB +: PC_W]  = in_pc_curr;
      wr_entry[PC_NEXT_LSB +: PC_W]  = in_pc_next;
      wr_entry[PRED_BIT]             = in_pred_taken;
`ifdef IFID_PREDECODE_EN
      wr_entry[BRANCH_BIT]           = (in_instr[15:13] == BRANCH_PFX);
      wr_entry[JUMP_BIT]             = (in_instr[15:13] == JUMP_PFX);
`endif
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      ifid_slot #(.W(ENTRY_W)) u_slot (
         .clk (clk),
         .rst (rst),
         .we  (push && (wr_idx == PW'(i))),
         .d   (wr_entry),
         .q   (slot_q[i])
      );
   end

   assign head_entry     = slot_q[head];
   assign out_valid      = (count != '0);
   assign out_instr      = out_valid ? head_entry[INSTR_LSB +: INSTR_W] : NOP_INSTR;
   assign out_pc_curr    = out_valid ? head_entry[PC_CURR_LSB +: PC_W] : '0;
   assign out_pc_next    = out_valid ? head_entry[PC_NEXT_LSB +: PC_W] : '0;
   assign out_pred_taken = out_valid && head_entry[PRED_BIT];

`ifdef IFID_PREDECODE_EN
   assign out_is_branch  = out_valid && head_entry[BRANCH_BIT];
   assign out_is_jump    = out_valid && head_entry[JUMP_BIT];
`else
   assign out_is_branch  = 1'b0;
   assign out_is_jump    = 1'b0;
`endif

   // A flush restarts the ring at slot 0; the redirected fetch, if any, becomes the sole entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         halt_seen <= 1'b0;
      end else if (flush) begin
         head      <= '0;
         tail      <= push ? PW'(1) : '0;
         count     <= push ? CW'(1) : '0;
         halt_seen <= push && in_halt;
      end else begin
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
         if (push && in_halt) begin
            halt_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ifid_queue.sv
// tb/tb_ifid_queue.sv - self-checking bench for ifid_queue against a queue-based model
module tb_ifid_queue;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_instr;
   logic [15:0] in_pc_curr;
   logic [15:0] in_pc_next;
   logic        in_pred_taken;
   logic        in_ready;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_instr;
   logic [15:0] out_pc_curr;
   logic [15:0] out_pc_next;
   logic        out_pred_taken;
   logic        out_is_branch;
   logic        out_is_jump;
   logic        halt_seen;
   logic [1:0]  count;
   logic        err;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc_curr;
      logic [15:0] pc_next;
      logic        pred;
   } ent_t;

   ent_t mq[$];
   bit   m_halt;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ifid_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_instr       (in_instr),
      .in_pc_curr     (in_pc_curr),
      .in_pc_next     (in_pc_next),
      .in_pred_taken  (in_pred_taken),
      .in_ready       (in_ready),
      .flush          (flush),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc_curr    (out_pc_curr),
      .out_pc_next    (out_pc_next),
      .out_pred_taken (out_pred_taken),
      .out_is_branch  (out_is_branch),
      .out_is_jump    (out_is_jump),
      .halt_seen      (halt_seen),
      .count          (count),
      .err            (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc, input logic pred);
      in_valid      = v;
      in_instr      = ins;
      in_pc_curr    = pc;
      in_pc_next    = pc + 16'd2;
      in_pred_taken = pred;
   endtask

   // Advance one clock edge and apply the queue rules to the model using the inputs held across it.
   task automatic tick();
      bit   r   = rst;
      bit   fl  = flush;
      bit   iv  = in_valid;
      bit   ordy = out_ready;
      bit   acc;
      ent_t e;
      e.instr   = in_instr;
      e.pc_curr = in_pc_curr;
      e.pc_next = in_pc_next;
      e.pred    = in_pred_taken;
      @(posedge clk);
      #1;
      if (!r) begin
         mq.delete();
         m_halt = 0;
      end else if (fl) begin
         mq.delete();
         m_halt = 0;
         if (iv) begin
            mq.push_back(e);
            m_halt = (e.instr[15:11] == 5'b00000);
         end
      end else begin
         acc = iv && (mq.size() < DEPTH) && !m_halt;
         if (mq.size() > 0 && ordy) void'(mq.pop_front());
         if (acc) begin
            mq.push_back(e);
            if (e.instr[15:11] == 5'b00000) m_halt = 1;
         end
      end
   endtask

   always @(negedge clk) begin : compare
      bit   exp_ready;
      bit   exp_br;
      bit   exp_jmp;
      ent_t h;
      exp_ready = (mq.size() < DEPTH) && !m_halt;
      chk("cmp_in_ready", in_ready, exp_ready);
      chk("cmp_err", err, in_valid && !exp_ready && !flush);
      chk("cmp_count", count, mq.size());
      chk("cmp_halt_seen", halt_seen, m_halt);
      exp_br  = 0;
      exp_jmp = 0;
      if (mq.size() > 0) begin
         h = mq[0];
`ifdef IFID_PREDECODE_EN
         exp_br  = (h.instr[15:13] == 3'b011);
         exp_jmp = (h.instr[15:13] == 3'b001);
`endif
         chk("cmp_out_valid", out_valid, 1);
         chk("cmp_out_instr", out_instr, h.instr);
         chk("cmp_out_pc_curr", out_pc_curr, h.pc_curr);
         chk("cmp_out_pc_next", out_pc_next, h.pc_next);
         chk("cmp_out_pred", out_pred_taken, h.pred);
      end else begin
         chk("cmp_out_valid", out_valid, 0);
         chk("cmp_out_instr", out_instr, 16'h0800);
         chk("cmp_out_pc_curr", out_pc_curr, 0);
         chk("cmp_out_pc_next", out_pc_next, 0);
         chk("cmp_out_pred", out_pred_taken, 0);
      end
      chk("cmp_is_branch", out_is_branch, exp_br);
      chk("cmp_is_jump", out_is_jump, exp_jmp);
   end

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      m_halt    = 0;
      drive(1, 16'h1234, 16'h0100, 0);
      repeat (3) tick();
      #1;
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 16'h0800);
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();

      // fill to full, third bundle dropped with err
      drive(1, 16'h1100, 16'h0000, 0);
      tick();
      drive(1, 16'h1202, 16'h0002, 1);
      tick();
      drive(1, 16'h1304, 16'h0004, 0);
      #1;
      chk("full_count", count, 2);
      chk("full_in_ready", in_ready, 0);
      chk("full_err", err, 1);
      chk("full_head_pc", out_pc_curr, 16'h0000);
      tick();
      #1;
      chk("drop_count", count, 2);
      chk("drop_head_pc", out_pc_curr, 16'h0000);
      in_valid = 1'b0;

      // pop one, then simultaneous push and pop at count 1
      out_ready = 1'b1;
      tick();
      #1;
      chk("pop_head_pc", out_pc_curr, 16'h0002);
      drive(1, 16'h1406, 16'h0006, 0);
      #1;
      chk("pp_err", err, 0);
      tick();
      #1;
      chk("pp_count", count, 1);
      chk("pp_head_pc", out_pc_curr, 16'h0006);

      // flush with redirected fetch while full
      out_ready = 1'b0;
      drive(1, 16'h1508, 16'h0008, 0);
      tick();
      flush = 1'b1;
      drive(1, 16'h2040, 16'h0040, 1);
      #1;
      chk("flush_err", err, 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush_count", count, 1);
      chk("flush_pc", out_pc_curr, 16'h0040);
      chk("flush_halt", halt_seen, 0);
      chk("flush_pred", out_pred_taken, 1);

      // HALT capture and drain
      out_ready = 1'b1;
      drive(1, 16'h0000, 16'h0010, 0);
      tick();
      #1;
      chk("halt_seen", halt_seen, 1);
      chk("halt_in_ready", in_ready, 0);
      chk("halt_head_pc", out_pc_curr, 16'h0010);
      chk("halt_head_instr", out_instr, 16'h0000);
      out_ready = 1'b0;
      drive(1, 16'h1600, 16'h0012, 0);
      #1;
      chk("halt_err", err, 1);
      tick();
      out_ready = 1'b1;
      tick();
      #1;
      chk("drain_valid", out_valid, 0);
      chk("drain_instr", out_instr, 16'h0800);
      chk("drain_halt", halt_seen, 1);
      chk("drain_err", err, 1);

      flush    = 1'b1;
      in_valid = 1'b0;
      tick();
      flush = 1'b0;
      #1;
      chk("unhalt_halt", halt_seen, 0);
      chk("unhalt_count", count, 0);
      chk("unhalt_in_ready", in_ready, 1);

      // predecode flags
      out_ready = 1'b0;
      drive(1, 16'h6005, 16'h0020, 0);
      tick();
      in_valid = 1'b0;
      #1;
`ifdef IFID_PREDECODE_EN
      chk("pd_branch", out_is_branch, 1);
`else
      chk("pd_branch", out_is_branch, 0);
`endif
      chk("pd_jump", out_is_jump, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("pd_flush_branch", out_is_branch, 0);
      chk("pd_flush_jump", out_is_jump, 0);

      // mixed push/pop pattern exercising pointer wrap
      for (int i = 0; i < 16; i++) begin
         logic [15:0] ins;
         ins = (i % 3 == 0) ? 16'h6000 + 16'(i) : (i % 3 == 1) ? 16'h2000 + 16'(i) : 16'h1000 + 16'(i);
         drive(((i % 4) != 3), ins, 16'h0100 + 16'(2 * i), 1'(i));
         out_ready = ((i % 3) != 0);
         tick();
      end

      // reset mid-operation
      out_ready = 1'b0;
      drive(1, 16'h1700, 16'h0200, 0);
      tick();
      tick();
      #1;
      rst = 1'b0;
      mq.delete();
      m_halt = 0;
      #1;
      chk("midrst_count", count, 0);
      chk("midrst_valid", out_valid, 0);
      in_valid = 1'b0;
      rst      = 1'b1;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
